alu4_arbiter: RTL and testbench

ALU4_ARBITER -- requirements
Module: alu4_arbiter

---
 rtl/alu4_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu4_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_arbiter.sv
// Two-requester round-robin front end for a shared 4-bit ALU.
// Each operation occupies the ALU for one cycle, and the response is held until the consumer accepts it.
module alu4_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req0_cin,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic       req1_cin,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_c,
    output logic       alu_cin,
    input  logic [3:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       alu_carry,
    input  logic       alu_size,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_flags
);

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state;
    logic                last_grant;
    logic [2:0]          op_r;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic                cin_r;

    logic                grant_any;
    logic                grant_idx;
    logic [2:0]          sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic                sel_cin;

    // Flags are {zero, overflow, carry, size}; only the meaningful ones survive per op class.
    function automatic logic [3:0] mask_flags(input logic [2:0] op, input logic z,
                                              input logic ov, input logic c, input logic s);
        case (op)
            3'b000, 3'b001: mask_flags = {1'b0, ov, c, 1'b0};
            3'b110, 3'b111: mask_flags = {z, ov, c, s};
            default:        mask_flags = 4'b0000;
        endcase
    endfunction

    always_comb begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_idx = ~last_grant;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_idx = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    always_comb begin
        sel_op  = req0_op;
        sel_a   = req0_a;
        sel_b   = req0_b;
        sel_cin = req0_cin;
        if (grant_idx) begin
            sel_op  = req1_op;
            sel_a   = req1_a;
            sel_b   = req1_b;
            sel_cin = req1_cin;
        end
    end

    assign req0_ready = grant_any && !grant_idx;
    assign req1_ready = grant_any && grant_idx;

    assign alu_a   = a_r;
    assign alu_b   = b_r;
    assign alu_c   = op_r;
    assign alu_cin = cin_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            cin_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_r       <= sel_op;
                        a_r        <= sel_a;
                        b_r        <= sel_b;
                        cin_r      <= sel_cin;
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= mask_flags(op_r, alu_zero, alu_overflow, alu_carry, alu_size);
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    // New grants wait for IDLE, so a response never overlaps the next request.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_arbiter.sv
// Directed and randomized bench for alu4_arbiter with a behavioural shared ALU
// and a transaction-level arbitration/response model.
module tb_alu4_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready, req0_cin;
    logic [2:0] req0_op;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_cin;
    logic [2:0] req1_op;
    logic [3:0] req1_a, req1_b;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_c;
    logic       alu_cin;
    logic [3:0] alu_result;
    logic       alu_zero, alu_overflow, alu_carry, alu_size;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_result, rsp_flags;

    int checks   = 0;
    int failures = 0;

    alu4_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry(alu_carry), .alu_size(alu_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {result[3:0], zero, overflow, carry(borrow for subtracts), size}.
    function automatic logic [7:0] gold_alu(input logic [2:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic cin);
        logic [4:0] wide;
        logic [3:0] r;
        logic       ov, c, s;
        ov = 1'b0;
        c  = 1'b0;
        r  = 4'h0;
        case (op)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b} + {4'b0, cin};
                r = wide[3:0]; c = wide[4];
                ov = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'd1: begin
                wide = {1'b0, a} - {1'b0, b} - {4'b0, cin};
                r = wide[3:0]; c = wide[4];
                ov = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            default: begin
                wide = {1'b0, a} - {1'b0, b};
                r = wide[3:0]; c = wide[4];
                ov = (a[3] != b[3]) && (r[3] != a[3]);
            end
        endcase
        s = (op == 3'd7) ? (a == b) : ($signed(a) < $signed(b));
        return {r, (r == 4'h0), ov, c, s};
    endfunction

    function automatic logic [3:0] exp_mask(input logic [2:0] op, input logic [3:0] f);
        if (op <= 3'd1)      return f & 4'b0110;
        else if (op >= 3'd6) return f;
        else                 return 4'b0000;
    endfunction

    always_comb {alu_result, alu_zero, alu_overflow, alu_carry, alu_size} =
        gold_alu(alu_c, alu_a, alu_b, alu_cin);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int who, output int waited);
        who = -1;
        waited = 0;
        for (int i = 0; i < 20 && who < 0; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) who = req1_ready ? 1 : 0;
            else begin
                tick();
                waited++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int          who, waited;
    logic        m_busy, m_last, m_id, hs, e0, e1, v0, v1;
    int          m_since;
    logic [3:0]  m_res, m_flags;
    logic [7:0]  g;

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'h0; req0_b = 4'h0; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 4'h0; req1_b = 4'h0; req1_cin = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_rdy0", 8'(req0_ready), 8'h0);
        chk("rst_rdy1", 8'(req1_ready), 8'h0);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'h0);
        chk("rst_rsp_id", 8'(rsp_id), 8'h0);
        chk("rst_rsp_result", 8'(rsp_result), 8'h0);
        chk("rst_rsp_flags", 8'(rsp_flags), 8'h0);
        chk("rst_alu_a", 8'(alu_a), 8'h0);
        chk("rst_alu_b", 8'(alu_b), 8'h0);
        chk("rst_alu_c", 8'(alu_c), 8'h0);
        chk("rst_alu_cin", 8'(alu_cin), 8'h0);

        // Single add with overflow
        tick();
        rst = 1'b0; req1_valid = 1'b0;
        req0_op = 3'd0; req0_a = 4'h7; req0_b = 4'h1; req0_cin = 1'b0;
        @(negedge clk);
        chk("add_rdy0", 8'(req0_ready), 8'h1);
        chk("add_rdy1", 8'(req1_ready), 8'h0);
        tick();
        req0_valid = 1'b0; req0_a = 4'hA;
        @(negedge clk);
        chk("add_exec_rsp_valid", 8'(rsp_valid), 8'h0);
        chk("add_alu_a", 8'(alu_a), 8'h7);
        chk("add_alu_b", 8'(alu_b), 8'h1);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("add_rsp_valid", 8'(rsp_valid), 8'h1);
        chk("add_rsp_id", 8'(rsp_id), 8'h0);
        chk("add_result", 8'(rsp_result), 8'h8);
        chk("add_flags", 8'(rsp_flags), 8'h4);
        tick();
        @(negedge clk);
        chk("add_idle_rsp_valid", 8'(rsp_valid), 8'h0);

        // Tie after reset: 0,1,0 back to back
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 4'h3; req0_b = 4'h5;
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 4'h6; req1_b = 4'h3;
        for (int k = 0; k < 3; k++) begin
            wait_grant(who, waited);
            chk($sformatf("tie_winner%0d", k), 8'(who), 8'(k % 2));
            if (k > 0) chk($sformatf("tie_gap%0d", k), 8'(waited), 8'h0);
            tick(); tick();
            @(negedge clk);
            chk($sformatf("tie_rsp_valid%0d", k), 8'(rsp_valid), 8'h1);
            chk($sformatf("tie_rsp_id%0d", k), 8'(rsp_id), 8'(k % 2));
            chk($sformatf("tie_result%0d", k), 8'(rsp_result), (k % 2 == 0) ? 8'h7 : 8'h5);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure on an equal compare, with req0 waiting
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd7; req1_a = 4'h5; req1_b = 4'h5; req1_cin = 1'b0;
        @(negedge clk);
        chk("bp_rdy1", 8'(req1_ready), 8'h1);
        tick();
        req1_valid = 1'b0; req0_valid = 1'b1; req0_op = 3'd2; req0_a = 4'h9;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 8'(rsp_valid), 8'h1);
            chk("bp_rsp_id", 8'(rsp_id), 8'h1);
            chk("bp_result", 8'(rsp_result), 8'h0);
            chk("bp_flags", 8'(rsp_flags), 8'h9);
            chk("bp_rdy0", 8'(req0_ready), 8'h0);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy0", 8'(req0_ready), 8'h0);
        chk("bp_release_valid", 8'(rsp_valid), 8'h1);
        tick();
        @(negedge clk);
        chk("bp_idle_rsp_valid", 8'(rsp_valid), 8'h0);
        chk("bp_idle_rdy0", 8'(req0_ready), 8'h1);
        tick();
        req0_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("not_result", 8'(rsp_result), 8'h6);
        chk("not_flags", 8'(rsp_flags), 8'h0);
        tick();

        // AND: flags masked off
        req0_valid = 1'b1; req0_op = 3'd3; req0_a = 4'hF; req0_b = 4'h3; req0_cin = 1'b0;
        @(negedge clk);
        chk("and_rdy0", 8'(req0_ready), 8'h1);
        tick(); req0_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("and_result", 8'(rsp_result), 8'h3);
        chk("and_flags", 8'(rsp_flags), 8'h0);
        tick();

        // Signed compare 2 vs 5
        req0_valid = 1'b1; req0_op = 3'd6; req0_a = 4'h2; req0_b = 4'h5; req0_cin = 1'b1;
        @(negedge clk);
        chk("cmp_rdy0", 8'(req0_ready), 8'h1);
        tick(); req0_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("cmp_result", 8'(rsp_result), 8'hD);
        chk("cmp_zero", 8'(rsp_flags[3]), 8'h0);
        chk("cmp_size", 8'(rsp_flags[0]), 8'h1);
        chk("cmp_flags", 8'(rsp_flags), 8'h3);
        tick();

        // Reset while in EXEC
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 4'h1; req1_b = 4'h1; req1_cin = 1'b0;
        @(negedge clk);
        chk("rstx_rdy1", 8'(req1_ready), 8'h1);
        tick();
        rst = 1'b1; req0_valid = 1'b1;
        @(negedge clk);
        chk("rstx_rdy0_in_rst", 8'(req0_ready), 8'h0);
        chk("rstx_rdy1_in_rst", 8'(req1_ready), 8'h0);
        tick();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstx_no_rsp", 8'(rsp_valid), 8'h0);
            tick();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("rstx_tie_rdy0", 8'(req0_ready), 8'h1);
        chk("rstx_tie_rdy1", 8'(req1_ready), 8'h0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();

        // Randomized traffic against the transaction model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_busy = 1'b0; m_last = 1'b1; m_since = 0; m_id = 1'b0; m_res = 4'h0; m_flags = 4'h0;
        for (int n = 0; n < 600; n++) begin
            req0_valid = ($urandom_range(0, 9) < 5);
            req1_valid = ($urandom_range(0, 9) < 5);
            req0_op = 3'($urandom_range(0, 7)); req0_a = 4'($urandom_range(0, 15));
            req0_b = 4'($urandom_range(0, 15)); req0_cin = 1'($urandom_range(0, 1));
            req1_op = 3'($urandom_range(0, 7)); req1_a = 4'($urandom_range(0, 15));
            req1_b = 4'($urandom_range(0, 15)); req1_cin = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (m_busy) m_since++;
            v0 = req0_valid; v1 = req1_valid;
            e0 = 1'b0; e1 = 1'b0;
            if (!m_busy) begin
                if (v0 && v1) begin
                    e0 = (m_last == 1'b1);
                    e1 = (m_last == 1'b0);
                end else begin
                    e0 = v0;
                    e1 = v1 && !v0;
                end
            end
            chk("rnd_rsp_valid", 8'(rsp_valid), 8'(m_busy && m_since >= 2));
            chk("rnd_rdy0", 8'(req0_ready), 8'(e0));
            chk("rnd_rdy1", 8'(req1_ready), 8'(e1));
            hs = m_busy && (m_since >= 2) && rsp_ready;
            if (hs) begin
                chk("rnd_rsp_id", 8'(rsp_id), 8'(m_id));
                chk("rnd_result", 8'(rsp_result), 8'(m_res));
                chk("rnd_flags", 8'(rsp_flags), 8'(m_flags));
                m_busy = 1'b0;
            end
            if (e0 || e1) begin
                m_busy = 1'b1; m_since = 0; m_id = e1; m_last = e1;
                g = e1 ? gold_alu(req1_op, req1_a, req1_b, req1_cin)
                       : gold_alu(req0_op, req0_a, req0_b, req0_cin);
                m_res = g[7:4];
                m_flags = exp_mask(e1 ? req1_op : req0_op, g[3:0]);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
